// File: rtl/uctl_aon_pwr_ctrl.sv
// Always-on power controller: takes the core to power-down after a held bus
// suspend and brings it back on bus activity or a software remote-wakeup.
module uctl_aon_pwr_ctrl #(
  parameter int CNT_WD = 16
) (
  input  logic              aon_clk,
  input  logic              aon_rst,
  input  logic              sw_rst,
  input  logic              suspend_en,
  input  logic              core_suspend,
  input  logic [CNT_WD-1:0] pd_delay,
  input  logic              core_pd_ack,
  input  logic              bus_activityIrq,
  input  logic              sw_wakeup,
  input  logic [CNT_WD-1:0] wake_settle,
  output logic              pd_req,
  output logic              power_down,
  output logic              wakeup_irq,
  output logic [1:0]        wake_src,
  output logic [2:0]        pwr_state
);

  typedef enum logic [2:0] {
    ST_ACTIVE    = 3'd0,
    ST_SUSP_WAIT = 3'd1,
    ST_PD_REQ    = 3'd2,
    ST_DOWN      = 3'd3,
    ST_WAKE      = 3'd4
  } pwr_state_e;

  pwr_state_e        state_q, state_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic              pd_req_q, pd_req_d;
  logic              power_down_q, power_down_d;
  logic              wakeup_irq_q, wakeup_irq_d;
  logic [1:0]        wake_src_q, wake_src_d;

  logic suspend_ok;
  logic wake_evt;

  assign suspend_ok = suspend_en & core_suspend;
  assign wake_evt   = bus_activityIrq | sw_wakeup;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wake_src_d   = wake_src_q;
    wakeup_irq_d = 1'b0;

    unique case (state_q)
      ST_ACTIVE: begin
        if (suspend_ok) begin
          state_d = ST_SUSP_WAIT;
          cnt_d   = '0;
        end
      end
      ST_SUSP_WAIT: begin
        if (!suspend_ok) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q == pd_delay) begin
          state_d = ST_PD_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WD'(1);
        end
      end
      ST_PD_REQ: begin
        // Any abort reason outranks an acknowledge arriving in the same cycle.
        if (!suspend_ok || wake_evt) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else if (core_pd_ack) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
        end
      end
      ST_DOWN: begin
        if (wake_evt) begin
          state_d    = ST_WAKE;
          cnt_d      = '0;
          wake_src_d = {sw_wakeup, bus_activityIrq};
        end
      end
      ST_WAKE: begin
        if (cnt_q == wake_settle) begin
          state_d      = ST_ACTIVE;
          cnt_d        = '0;
          wakeup_irq_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WD'(1);
        end
      end
      default: begin
        state_d = ST_ACTIVE;
        cnt_d   = '0;
      end
    endcase

    if (sw_rst) begin
      state_d      = ST_ACTIVE;
      cnt_d        = '0;
      wake_src_d   = 2'b00;
      wakeup_irq_d = 1'b0;
    end

    // Outputs are decoded from the state being entered so they line up with it.
    pd_req_d     = (state_d == ST_PD_REQ);
    power_down_d = (state_d == ST_DOWN);
  end

  always_ff @(posedge aon_clk or posedge aon_rst) begin
    if (aon_rst) begin
      state_q      <= ST_ACTIVE;
      cnt_q        <= '0;
      pd_req_q     <= 1'b0;
      power_down_q <= 1'b0;
      wakeup_irq_q <= 1'b0;
      wake_src_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pd_req_q     <= pd_req_d;
      power_down_q <= power_down_d;
      wakeup_irq_q <= wakeup_irq_d;
      wake_src_q   <= wake_src_d;
    end
  end

  assign pd_req     = pd_req_q;
  assign power_down = power_down_q;
  assign wakeup_irq = wakeup_irq_q;
  assign wake_src   = wake_src_q;
  assign pwr_state  = state_q;

endmodule

// File: tb/tb_uctl_aon_pwr_ctrl.sv
// Self-checking bench for uctl_aon_pwr_ctrl: vector table, directed corner
// sequences, and randomized traffic against a dwell-time reference model.
module tb_uctl_aon_pwr_ctrl;

  logic        aon_clk = 1'b0;
  logic        aon_rst = 1'b1;
  logic        sw_rst = 1'b0;
  logic        suspend_en = 1'b0;
  logic        core_suspend = 1'b0;
  logic [15:0] pd_delay = 16'd0;
  logic        core_pd_ack = 1'b0;
  logic        bus_activityIrq = 1'b0;
  logic        sw_wakeup = 1'b0;
  logic [15:0] wake_settle = 16'd0;
  logic        pd_req, power_down, wakeup_irq;
  logic [1:0]  wake_src;
  logic [2:0]  pwr_state;

  int n_checks = 0;
  int n_fail = 0;

  uctl_aon_pwr_ctrl #(.CNT_WD(16)) dut (
    .aon_clk(aon_clk), .aon_rst(aon_rst), .sw_rst(sw_rst),
    .suspend_en(suspend_en), .core_suspend(core_suspend), .pd_delay(pd_delay),
    .core_pd_ack(core_pd_ack), .bus_activityIrq(bus_activityIrq),
    .sw_wakeup(sw_wakeup), .wake_settle(wake_settle), .pd_req(pd_req),
    .power_down(power_down), .wakeup_irq(wakeup_irq), .wake_src(wake_src),
    .pwr_state(pwr_state)
  );

  always #5 aon_clk = ~aon_clk;

  typedef struct {
    logic       srst, se, cs, ack, bus, sw;
    logic [1:0] pdd, wsl;
    logic       e_pdreq, e_pd, e_irq;
    logic [1:0] e_src;
    logic [2:0] e_st;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aon_clk);
    #1;
  endtask

  task automatic idle_inputs();
    sw_rst = 0; suspend_en = 0; core_suspend = 0; core_pd_ack = 0;
    bus_activityIrq = 0; sw_wakeup = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pdreq"}, 32'(pd_req), 0);
    check({tag, "_pd"}, 32'(power_down), 0);
    check({tag, "_irq"}, 32'(wakeup_irq), 0);
    check({tag, "_src"}, 32'(wake_src), 0);
    check({tag, "_st"}, 32'(pwr_state), 0);
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int limit, input string tag);
    int n = 0;
    while (pwr_state !== tgt && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(pwr_state == tgt), 1);
  endtask

  // Reference model: tracks the spec-level state number and how many cycles
  // have been spent in it, and exits a dwell once that reaches delay+1.
  int         m_st, m_age;
  logic       m_irq;
  logic [1:0] m_src;

  task automatic m_go(input int s);
    m_st = s;
    m_age = 1;
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 1; m_irq = 0; m_src = 0;
  endtask

  task automatic model_step();
    m_irq = 0;
    if (sw_rst) begin
      model_reset();
      return;
    end
    case (m_st)
      0: if (suspend_en && core_suspend) m_go(1);
      1: begin
        if (!suspend_en || !core_suspend) m_go(0);
        else if (m_age == int'(pd_delay) + 1) m_go(2);
        else m_age++;
      end
      2: begin
        if (!suspend_en || !core_suspend || bus_activityIrq || sw_wakeup) m_go(0);
        else if (core_pd_ack) m_go(3);
      end
      3: if (bus_activityIrq || sw_wakeup) begin
        m_src = {sw_wakeup, bus_activityIrq};
        m_go(4);
      end
      default: begin
        if (m_age == int'(wake_settle) + 1) begin
          m_irq = 1;
          m_go(0);
        end else m_age++;
      end
    endcase
  endtask

  initial begin
    int sw_cnt, pr_cnt, wk_cnt, irq_cnt, n;

    //            srst se cs ack bus sw pdd wsl | pdreq pd irq src st
    vecs[0]  = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 3'd1};
    vecs[1]  = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 3'd1};
    vecs[2]  = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00, 3'd2};
    vecs[3]  = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 2'b00, 3'd2};
    vecs[4]  = '{0, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 2'b00, 3'd3};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 2'b00, 3'd3};
    vecs[6]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2'b01, 3'd4};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 3'd4};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2'b01, 3'd0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 3'd0};
    vecs[10] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 3'd1};
    vecs[11] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 3'd1};
    vecs[12] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 2'b01, 3'd2};
    vecs[13] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 2'b01, 3'd0};
    vecs[14] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 3'd1};
    vecs[15] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 3'd0};
    vecs[16] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 3'd1};
    vecs[17] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 3'd1};
    vecs[18] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 2'b01, 3'd2};
    vecs[19] = '{0, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 2'b01, 3'd3};
    vecs[20] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 2'b11, 3'd4};
    vecs[21] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b11, 3'd4};
    vecs[22] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2'b11, 3'd0};
    vecs[23] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 3'd0};

    // Reset state
    #12;
    check_all_zero("reset");
    aon_rst = 0;
    tick();
    check_all_zero("post_reset");

    // Vector table
    for (int i = 0; i < 24; i++) begin
      sw_rst = vecs[i].srst; suspend_en = vecs[i].se; core_suspend = vecs[i].cs;
      core_pd_ack = vecs[i].ack; bus_activityIrq = vecs[i].bus; sw_wakeup = vecs[i].sw;
      pd_delay = 16'(vecs[i].pdd); wake_settle = 16'(vecs[i].wsl);
      tick();
      check($sformatf("vec%0d_pdreq", i), 32'(pd_req), 32'(vecs[i].e_pdreq));
      check($sformatf("vec%0d_pd", i), 32'(power_down), 32'(vecs[i].e_pd));
      check($sformatf("vec%0d_irq", i), 32'(wakeup_irq), 32'(vecs[i].e_irq));
      check($sformatf("vec%0d_src", i), 32'(wake_src), 32'(vecs[i].e_src));
      check($sformatf("vec%0d_st", i), 32'(pwr_state), 32'(vecs[i].e_st));
    end
    idle_inputs();
    tick();

    // pd_delay=3 gives 4 SUSP_WAIT cycles; ack after 2 cycles of pd_req
    pd_delay = 3; suspend_en = 1; core_suspend = 1;
    sw_cnt = 0; pr_cnt = 0; n = 0;
    while (!power_down && n < 50) begin
      tick();
      n++;
      if (pwr_state == 3'd1) sw_cnt++;
      if (pd_req) begin
        pr_cnt++;
        if (pr_cnt == 2) core_pd_ack = 1;
      end
    end
    check("t1_susp_cycles", 32'(sw_cnt), 4);
    check("t1_pdreq_cycles", 32'(pr_cnt), 2);
    check("t1_power_down", 32'(power_down), 1);

    // Bus wake with wake_settle=7
    idle_inputs();
    wake_settle = 7;
    bus_activityIrq = 1;
    tick();
    bus_activityIrq = 0;
    check("t3_pd_released", 32'(power_down), 0);
    check("t3_src", 32'(wake_src), 32'b01);
    wk_cnt = (pwr_state == 3'd4) ? 1 : 0;
    irq_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pwr_state == 3'd4) wk_cnt++;
      if (wakeup_irq) irq_cnt++;
    end
    check("t3_wake_cycles", 32'(wk_cnt), 8);
    check("t3_irq_pulses", 32'(irq_cnt), 1);
    check("t3_final_state", 32'(pwr_state), 0);

    // Async reset while in DOWN
    pd_delay = 0; suspend_en = 1; core_suspend = 1; core_pd_ack = 1;
    wait_state(3'd3, 20, "t6_reach_down");
    idle_inputs();
    #2 aon_rst = 1;
    #1;
    check_all_zero("t6_async");
    #3 aon_rst = 0;
    tick();
    check_all_zero("t6_async_rel");

    // Software reset while in WAKE
    suspend_en = 1; core_suspend = 1; core_pd_ack = 1;
    wait_state(3'd3, 20, "t6_reach_down2");
    idle_inputs();
    sw_wakeup = 1;
    tick();
    sw_wakeup = 0;
    check("t6_in_wake", 32'(pwr_state), 4);
    check("t6_src_sw", 32'(wake_src), 32'b10);
    sw_rst = 1;
    tick();
    sw_rst = 0;
    check_all_zero("t6_swrst");

    // Randomized traffic against the reference model
    model_reset();
    pd_delay = 2; wake_settle = 2;
    for (int i = 0; i < 3000; i++) begin
      if (m_st == 0 && $urandom_range(7) == 0) begin
        pd_delay = 16'($urandom_range(5));
        wake_settle = 16'($urandom_range(5));
      end
      suspend_en = ($urandom_range(15) != 0);
      core_suspend = ($urandom_range(7) != 0);
      core_pd_ack = $urandom_range(1) == 1;
      bus_activityIrq = ($urandom_range(11) == 0);
      sw_wakeup = ($urandom_range(15) == 0);
      sw_rst = ($urandom_range(63) == 0);
      model_step();
      tick();
      check("rnd_st", 32'(pwr_state), 32'(m_st));
      check("rnd_pdreq", 32'(pd_req), 32'(m_st == 2));
      check("rnd_pd", 32'(power_down), 32'(m_st == 3));
      check("rnd_irq", 32'(wakeup_irq), 32'(m_irq));
      check("rnd_src", 32'(wake_src), 32'(m_src));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
